// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable word memory behind a single-outstanding valid/ready load/store port.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module data_memory_lsu #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic               we_q, we_d;
    logic               err_q, err_d;

    logic [31:0]        mem_q [DEPTH];

    logic               accept;
    logic [IDX_W-1:0]   req_idx;
    logic [1:0]         req_off;
    logic               req_fault;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic               unused_addr_bits;

    // Upper address bits only wrap; they never select anything.
    assign unused_addr_bits = ^req_addr;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[IDX_W+1:2];

    always_comb begin
        req_off   = req_addr[1:0];
        req_fault = 1'b0;
        unique case (req_size)
            2'b00: req_off = req_addr[1:0];
            2'b01: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                req_fault = req_addr[0];
`else
                req_fault = 1'b0;
`endif
                req_off = {req_addr[1], 1'b0};
            end
            2'b10: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                req_fault = |req_addr[1:0];
`else
                req_fault = 1'b0;
`endif
                req_off = 2'b00;
            end
            default: req_fault = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        unique case (req_size)
            2'b00: begin
                wr_be   = 4'b0001 << req_off;
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = req_off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'b10: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
        if (!accept || !req_we || req_fault || rst) begin
            wr_be = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem_q[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d  = req_idx;
                    off_d  = req_off;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    we_d   = req_we;
                    err_d  = req_fault;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;

    always_comb begin
        rd_word   = mem_q[idx_q];
        rd_byte   = rd_word[{off_q, 3'b000} +: 8];
        rd_half   = off_q[1] ? rd_word[31:16] : rd_word[15:0];
        rsp_rdata = 32'h0;
        if (rsp_valid && !we_q && !err_q) begin
            unique case (size_q)
                2'b00: rsp_rdata = uns_q ? {24'h0, rd_byte}
                                         : {{24{rd_byte[7]}}, rd_byte};
                2'b01: rsp_rdata = uns_q ? {16'h0, rd_half}
                                         : {{16{rd_half[15]}}, rd_half};
                2'b10: rsp_rdata = rd_word;
                default: rsp_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed vector table, reset corner sequences, zero-wait
// back-to-back handshake, and random traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_memory_lsu;
    localparam int DEPTH  = 64;
    localparam int WS     = 1;
    localparam int NBYTES = 4 * DEPTH;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_we0, req_unsigned0;
    logic [1:0]  req_size0;
    logic [31:0] req_addr0, req_wdata0;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    logic [7:0]  model_mem [NBYTES];

    int n_checks = 0;
    int n_errors = 0;

    data_memory_lsu #(
        .DEPTH(DEPTH), .ADDR_WIDTH(32), .WAIT_STATES(WS)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_memory_lsu #(
        .DEPTH(DEPTH), .ADDR_WIDTH(32), .WAIT_STATES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_size(req_size0),
        .req_unsigned(req_unsigned0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, little-endian, address modulo size.
    task automatic model_xact(input logic we, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
        int unsigned a, n;
        longint unsigned v;
        rd = 32'h0;
        er = 1'b0;
        if (sz == 2'b11) begin
            er = 1'b1;
            return;
        end
        n = 1 << sz;
        a = addr % NBYTES;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % n != 0) begin
            er = 1'b1;
            return;
        end
`endif
        a = a - (a % n);
        if (we) begin
            for (int i = 0; i < int'(n); i++)
                model_mem[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
            return;
        end
        v = 0;
        for (int i = 0; i < int'(n); i++)
            v += longint'(model_mem[a + i]) << (8 * i);
        if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
        rd = v[31:0];
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int busy,
                        output logic [31:0] rd, output logic er);
        check("ready_idle", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        busy = 0;
        rd = 32'h0;
        er = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (!req_ready) busy++;
            if (rsp_valid) begin
                lat = k;
                rd = rsp_rdata;
                er = rsp_err;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        check("rsp_quiet", {29'b0, rsp_valid, rsp_err, |rsp_rdata}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat, busy;
        logic [31:0] rd;
        logic er;
        xact(v.we, v.size, v.uns, v.addr, v.wdata, lat, busy, rd, er);
        check({name, "_lat"}, 32'(lat), 32'(WS + 1));
        check({name, "_busy"}, 32'(busy), 32'(WS + 1));
        check({name, "_rdata"}, rd, v.exp_rdata);
        check({name, "_err"}, {31'b0, er}, {31'b0, v.exp_err});
    endtask

    task automatic rand_step(input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] wd, input string name);
        logic [31:0] erd, rd;
        logic eer, er;
        int lat, busy;
        model_xact(we, sz, uns, addr, wd, erd, eer);
        xact(we, sz, uns, addr, wd, lat, busy, rd, er);
        check({name, "_lat"}, 32'(lat), 32'(WS + 1));
        check({name, "_rdata"}, rd, erd);
        check({name, "_err"}, {31'b0, er}, {31'b0, eer});
    endtask

    initial begin
        vec_t vecs[15];
        int pulses;
        logic [31:0] wrap_addr;

        wrap_addr = 32'h10 + 32'(4 * DEPTH);
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h00000080, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, wrap_addr, 32'h0, 32'hDEAD80EF, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1};
`else
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'hDEAD80EF, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'hFFFFDEAD, 1'b0};
`endif
        vecs[11] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF80EF, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_size0 = 2'b00;
        req_unsigned0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, req_ready}, 32'h1);
        check("reset_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_err", {31'b0, rsp_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset coinciding with a store acceptance.
        run_vec(vec_t'{1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0}, "pre20");
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h20; req_wdata = 32'h11111111; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        check("rst_acc_ready", {31'b0, req_ready}, 32'h1);
        pulses = 0;
        repeat (4) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        check("rst_acc_norsp", 32'(pulses), 32'h0);
        run_vec(vec_t'{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0}, "post20");

        // Reset while waiting: response dropped, committed store kept.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h24; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait_ready", {31'b0, req_ready}, 32'h1);
        pulses = 0;
        repeat (4) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        check("rst_wait_norsp", 32'(pulses), 32'h0);
        run_vec(vec_t'{1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'hA5A5A5A5, 1'b0}, "post24");

        // Zero wait states, req_valid held high.
        req_addr0 = 32'h40; req_we0 = 1'b1; req_size0 = 2'b10;
        req_wdata0 = 32'h5A5A0F0F;
        check("ws0_ready", {31'b0, req_ready0}, 32'h1);
        req_valid0 = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid0) pulses++;
            check($sformatf("ws0_valid%0d", k), {31'b0, rsp_valid0},
                  (k % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("ws0_ready%0d", k), {31'b0, req_ready0},
                  (k % 2 == 0) ? 32'h0 : 32'h1);
        end
        req_valid0 = 1'b0;
        check("ws0_pulses", 32'(pulses), 32'd5);
        req_we0 = 1'b0;
        req_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        check("ws0_ld_valid", {31'b0, rsp_valid0}, 32'h1);
        check("ws0_ld_rdata", rsp_rdata0, 32'h5A5A0F0F);
        check("ws0_ld_err", {31'b0, rsp_err0}, 32'h0);
        @(negedge clk);

        // Random traffic after defining every memory byte.
        for (int i = 0; i < DEPTH; i++)
            rand_step(1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom(),
                      $sformatf("fill%0d", i));
        for (int i = 0; i < 300; i++)
            rand_step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom(), $urandom(),
                      $sformatf("rnd%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory_lsu.md
DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width.
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning the extra cycles between acceptance and response (0..15).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  meaning a request is presented.
REQ-007 SHALL have port req_ready  output  1  meaning the block can accept a request this cycle.
REQ-008 SHALL have port req_we  input  1  meaning store (1) or load (0).
REQ-009 SHALL have port req_size  input  2  meaning 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port req_unsigned  input  1  meaning zero-extend load data (LBU/LHU) instead of sign-extend.
REQ-011 SHALL have port req_addr  input  ADDR_WIDTH  meaning the byte address.
REQ-012 SHALL have port req_wdata  input  32  meaning store data, right-aligned (bits [7:0] for byte).
REQ-013 SHALL have port rsp_valid  output  1  meaning a one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata  output  32  meaning extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  meaning the request faulted and had no effect on memory.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, capturing all req_* fields.
REQ-018 SHALL go IDLE->RESP on acceptance when WAIT_STATES = 0, else IDLE->WAIT with a down-counter loaded with WAIT_STATES-1, and WAIT->RESP when the counter is 0.
REQ-019 SHALL assert rsp_valid for exactly the one cycle spent in RESP, i.e. WAIT_STATES+1 cycles after acceptance, then return to IDLE.
REQ-020 SHALL ignore req_valid while req_ready = 0; there is at most one outstanding request.
REQ-021 SHALL index words with req_addr[log2(DEPTH)+1:2]; higher address bits are ignored (wrap-around modulo 4*DEPTH bytes).
REQ-022 SHALL commit a store at the acceptance edge, writing only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2 and +1; word: all four); other lanes are unchanged.
REQ-023 SHALL read load data at the RESP cycle, select the addressed lane(s), and sign- or zero-extend to 32 bits per req_unsigned; req_unsigned is ignored for word loads.
REQ-024 SHALL, for req_size = 11, perform no write and respond with rsp_err = 1, rsp_rdata = 0.
REQ-025 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid = 0.
REQ-026 SHALL return pre-store data for a load accepted in the cycle after a store only if ordering is violated; it SHALL NOT: a load always observes every previously accepted store.

Reset
REQ-027 SHALL, on any rising edge with rst = 1, force state IDLE, counter 0, req_ready = 1 on the following cycle, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-028 SHALL give rst priority over a simultaneous acceptance: no store is committed and no response is produced.
REQ-029 SHALL, on reset during WAIT or RESP, drop the pending response; a store already committed at acceptance remains in memory.
REQ-030 SHALL NOT clear memory contents on reset; contents are undefined until written.

Configuration
REQ-031 SHALL, with macro DMEM_MISALIGN_TRAP_EN defined, treat half accesses with addr[0] = 1 and word accesses with addr[1:0] != 00 as faults: no write, rsp_err = 1, rsp_rdata = 0, same latency.
REQ-032 SHALL, without DMEM_MISALIGN_TRAP_EN, force misaligned addresses down to natural alignment (clear addr[0] for half, addr[1:0] for word) and complete normally with rsp_err = 0.

Verification
REQ-033 SHALL cover: store word 0xDEADBEEF at 0x10, load word 0x10 (WAIT_STATES=1) -> rsp_valid exactly 2 cycles after each acceptance, rdata 0xDEADBEEF, req_ready low for 2 cycles.
REQ-034 SHALL cover: store byte 0x80 at 0x11 over 0xDEADBEEF, load LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
REQ-035 SHALL cover: LH 0x12 -> 0xFFFFDEAD, LHU 0x12 -> 0x0000DEAD; LW at 0x10 + 4*DEPTH -> same word as 0x10 (wrap).
REQ-036 SHALL cover: LW at 0x12 -> rsp_err = 1, rdata 0 with DMEM_MISALIGN_TRAP_EN; rdata = word at 0x10, err 0 without.
REQ-037 SHALL cover: req_size = 11 store to 0x10 -> rsp_err = 1 and subsequent LW 0x10 unchanged; rst asserted in the acceptance cycle of a store 0x11111111 to 0x20 -> no rsp_valid, location 0x20 unchanged.
REQ-038 SHALL cover: req_valid held high continuously with WAIT_STATES = 0 -> one acceptance every 2 cycles, rsp_valid pulses alternate with req_ready.
